epb_reg_slave: RTL and testbench

//  Parametrised EPB slave: synchronises PPC EPB strobes into clk, decodes a flat register space of
//  NUM_WR read/write control regs plus NUM_RD read-only status regs, returns epb_rdy after a

---
 rtl/epb_reg_slave_pkg.sv | 21 ++
 rtl/epb_reg_slave_sync.sv | 32 +++
 rtl/epb_reg_slave.sv | 207 ++++++++++++++++++++
 tb/tb_epb_reg_slave.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/epb_reg_slave_pkg.sv
// ============================================================================
// Module   : epb_reg_slave_pkg
// Purpose  : Shared FSM state encoding and wait-counter width for the EPB slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package epb_reg_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } epb_state_t;

    localparam int c_cnt_w = 4;

endpackage

`default_nettype wire

// File: rtl/epb_reg_slave_sync.sv
// ============================================================================
// Module   : epb_reg_slave_sync
// Purpose  : N-stage single-bit synchroniser with selectable reset level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module epb_reg_slave_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/epb_reg_slave.sv
// ============================================================================
// Module   : epb_reg_slave
// Purpose  : EPB slave with R/W control regs, RO status regs, strobes and
//            sticky access-error flag; strobes are synchronised into clk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module epb_reg_slave
    import epb_reg_slave_pkg::*;
#(
    parameter int                         ADDR_W      = 6,
    parameter int                         DATA_W      = 8,
    parameter int                         NUM_WR      = 8,
    parameter int                         NUM_RD      = 8,
    parameter int                         WAIT_STATES = 1,
    parameter int                         SYNC_STAGES = 2,
    parameter logic [NUM_WR*DATA_W-1:0]   WR_RESET    = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      epb_cs_n,
    input  logic                      epb_oe_n,
    input  logic                      epb_wr_n,
    input  logic [ADDR_W-1:0]         epb_addr,
    input  logic [DATA_W-1:0]         epb_data_i,
    output logic [DATA_W-1:0]         epb_data_o,
    output logic                      epb_data_oe,
    output logic                      epb_rdy,
    output logic [NUM_WR*DATA_W-1:0]  wr_regs,
    output logic [NUM_WR-1:0]         wr_stb,
    input  logic [NUM_RD*DATA_W-1:0]  rd_regs,
    output logic [NUM_RD-1:0]         rd_stb,
    output logic                      access_err,
    input  logic                      err_clr
);

    localparam logic [c_cnt_w-1:0] c_wait    = c_cnt_w'(WAIT_STATES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [2:0]                 w_strb_raw;
    logic [2:0]                 w_strb_s;
    logic                       w_cs_n_s;
    logic                       w_oe_n_s;
    logic                       w_wr_n_s;

    epb_state_t                 r_state;
    epb_state_t                 w_state_nxt;
    logic [c_cnt_w-1:0]         r_cnt;
    logic [c_cnt_w-1:0]         w_cnt_nxt;

    logic [ADDR_W-1:0]          r_addr;
    logic                       r_rd_txn;
    logic [DATA_W-1:0]          r_wdata;
    logic [NUM_WR*DATA_W-1:0]   r_wr_regs;
    logic [DATA_W-1:0]          r_data_o;
    logic                       r_data_oe;
    logic                       r_rdy;
    logic [NUM_WR-1:0]          r_wr_stb;
    logic [NUM_RD-1:0]          r_rd_stb;
    logic                       r_err;

    logic [NUM_WR-1:0]          w_wr_hit;
    logic [NUM_RD-1:0]          w_ro_hit;
    logic [DATA_W-1:0]          w_rd_data;
    logic                       w_unmapped;

    assign w_strb_raw = {epb_wr_n, epb_oe_n, epb_cs_n};

    // Idle level of every strobe is high, so the chains reset to 1
    for (genvar g = 0; g < 3; g++) begin : g_sync
        epb_reg_slave_sync #(
            .STAGES  (SYNC_STAGES),
            .RST_VAL (1'b1)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (w_strb_raw[g]),
            .q     (w_strb_s[g])
        );
    end

    assign w_cs_n_s = w_strb_s[0];
    assign w_oe_n_s = w_strb_s[1];
    assign w_wr_n_s = w_strb_s[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // WAIT lasts exactly WAIT_STATES cycles; a released cs_n there aborts
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs_n_s) begin
                    w_cnt_nxt   = c_wait;
                    w_state_nxt = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_cs_n_s) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt <= c_cnt_one) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            ST_ACK:  w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (w_cs_n_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wr_hit  = '0;
        w_ro_hit  = '0;
        w_rd_data = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (r_addr == ADDR_W'(i)) begin
                w_wr_hit[i] = 1'b1;
                w_rd_data   = r_wr_regs[i*DATA_W +: DATA_W];
            end
        end
        for (int j = 0; j < NUM_RD; j++) begin
            if (r_addr == ADDR_W'(NUM_WR + j)) begin
                w_ro_hit[j] = 1'b1;
                w_rd_data   = rd_regs[j*DATA_W +: DATA_W];
            end
        end
        w_unmapped = ~((|w_wr_hit) | (|w_ro_hit));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_rd_txn  <= 1'b0;
            r_wdata   <= '0;
            r_wr_regs <= WR_RESET;
            r_data_o  <= '0;
            r_data_oe <= 1'b0;
            r_rdy     <= 1'b0;
            r_wr_stb  <= '0;
            r_rd_stb  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_wr_stb <= '0;
            r_rd_stb <= '0;

            if (r_state == ST_IDLE && !w_cs_n_s) begin
                r_addr   <= epb_addr;
                r_rd_txn <= w_wr_n_s;
                r_wdata  <= epb_data_i;
            end

            if (r_state == ST_ACK) begin
                r_rdy <= 1'b1;
                if (!r_rd_txn) begin
                    for (int i = 0; i < NUM_WR; i++) begin
                        if (w_wr_hit[i]) begin
                            r_wr_regs[i*DATA_W +: DATA_W] <= r_wdata;
                        end
                    end
                    r_wr_stb <= w_wr_hit;
                end else begin
                    r_data_o <= w_rd_data;
                    r_rd_stb <= w_ro_hit;
                end
            end else if (r_state == ST_HOLD && w_cs_n_s) begin
                r_rdy <= 1'b0;
            end

            // A new error outranks a simultaneous clear
            if (r_state == ST_ACK && w_unmapped) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end

            r_data_oe <= r_rd_txn & ~w_oe_n_s &
                         ((r_state == ST_ACK) | ((r_state == ST_HOLD) & ~w_cs_n_s));
        end
    end

    assign epb_data_o  = r_data_o;
    assign epb_data_oe = r_data_oe;
    assign epb_rdy     = r_rdy;
    assign wr_regs     = r_wr_regs;
    assign wr_stb      = r_wr_stb;
    assign rd_stb      = r_rd_stb;
    assign access_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_epb_reg_slave.sv
// ============================================================================
// Module   : tb_epb_reg_slave
// Purpose  : Self-checking bench for epb_reg_slave with a cycle-level
//            transaction model, random traffic and directed corner cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_epb_reg_slave;

    localparam int          SYNC   = 2;
    localparam int          LAT_A  = SYNC + 1 + 1;
    localparam int          LAT_B  = SYNC + 4 + 1;
    localparam logic [63:0] WR_RST = 64'h8877_6655_4433_225A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n, cs_n_b, oe_n, wr_n, err_clr;
    logic [5:0]  addr;
    logic [7:0]  data_i;
    logic [63:0] rd_regs;

    logic [7:0]  data_o,  data_o_b;
    logic        data_oe, data_oe_b, rdy, rdy_b, err, err_b;
    logic [63:0] wr_regs, wr_regs_b;
    logic [7:0]  wr_stb, wr_stb_b, rd_stb, rd_stb_b;

    always #5 clk = ~clk;

    epb_reg_slave #(
        .ADDR_W(6), .DATA_W(8), .NUM_WR(8), .NUM_RD(8),
        .WAIT_STATES(1), .SYNC_STAGES(SYNC), .WR_RESET(WR_RST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .epb_cs_n(cs_n), .epb_oe_n(oe_n), .epb_wr_n(wr_n),
        .epb_addr(addr), .epb_data_i(data_i), .epb_data_o(data_o), .epb_data_oe(data_oe),
        .epb_rdy(rdy), .wr_regs(wr_regs), .wr_stb(wr_stb), .rd_regs(rd_regs),
        .rd_stb(rd_stb), .access_err(err), .err_clr(err_clr)
    );

    epb_reg_slave #(
        .ADDR_W(6), .DATA_W(8), .NUM_WR(8), .NUM_RD(8),
        .WAIT_STATES(4), .SYNC_STAGES(SYNC), .WR_RESET(WR_RST)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .epb_cs_n(cs_n_b), .epb_oe_n(oe_n), .epb_wr_n(wr_n),
        .epb_addr(addr), .epb_data_i(data_i), .epb_data_o(data_o_b), .epb_data_oe(data_oe_b),
        .epb_rdy(rdy_b), .wr_regs(wr_regs_b), .wr_stb(wr_stb_b), .rd_regs(rd_regs),
        .rd_stb(rd_stb_b), .access_err(err_b), .err_clr(1'b0)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the main instance
    logic [7:0]  m_regs [8];
    logic        m_rdy, m_oe, m_err;
    logic [7:0]  m_data, m_wr_stb, m_rd_stb;
    bit          cmp_en = 1'b0;
    int          fall_cd = 0;
    bit          prev_rdy = 1'b0;
    bit          rose;
    int          rises, wr_pulses, rd_pulses;
    logic [7:0]  last_wr, last_rd;
    bit          oe_seen;

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [63:0] pk;
            for (int i = 0; i < 8; i++) pk[i*8 +: 8] = m_regs[i];
            chk("wr_regs", wr_regs, pk);
            chk("epb_rdy", {63'd0, rdy}, {63'd0, m_rdy});
            chk("epb_data_oe", {63'd0, data_oe}, {63'd0, m_oe});
            chk("epb_data_o", {56'd0, data_o}, {56'd0, m_data});
            chk("wr_stb", {56'd0, wr_stb}, {56'd0, m_wr_stb});
            chk("rd_stb", {56'd0, rd_stb}, {56'd0, m_rd_stb});
            chk("access_err", {63'd0, err}, {63'd0, m_err});
        end
    end

    // One clock edge: retire last cycle's strobes, apply err_clr and pending cs_n release
    task automatic tick();
        logic clr;
        @(posedge clk);
        clr = err_clr;
        #1;
        m_wr_stb = '0;
        m_rd_stb = '0;
        if (clr) m_err = 1'b0;
        if (fall_cd > 0) begin
            fall_cd--;
            if (fall_cd == 0) begin
                m_rdy = 1'b0;
                m_oe  = 1'b0;
            end
        end
        rose = rdy && !prev_rdy;
        if (rose) rises++;
        prev_rdy = rdy;
        if (wr_stb != 0) begin wr_pulses++; last_wr = wr_stb; end
        if (rd_stb != 0) begin rd_pulses++; last_rd = rd_stb; end
        if (data_oe) oe_seen = 1'b1;
    endtask

    task automatic do_txn(input logic [5:0] a, input bit wr, input logic [7:0] d, input bit oel,
                          input int hold, input int gap, input int clr_k);
        int rise_k;
        rise_k = -1;
        @(negedge clk);
        addr   = a;
        wr_n   = !wr;
        data_i = d;
        oe_n   = !(!wr && oel);
        cs_n   = 1'b0;
        for (int k = 0; k <= LAT_A + hold; k++) begin
            err_clr = (k == clr_k);
            tick();
            if (rose) rise_k = k;
            if (k == LAT_A) begin
                m_rdy = 1'b1;
                if (wr) begin
                    if (a < 8) begin
                        m_regs[a[2:0]] = d;
                        m_wr_stb = 8'd1 << a[2:0];
                    end else if (a >= 16) begin
                        m_err = 1'b1;
                    end
                end else begin
                    if (a < 8) begin
                        m_data = m_regs[a[2:0]];
                    end else if (a < 16) begin
                        m_data   = rd_regs[(int'(a) - 8)*8 +: 8];
                        m_rd_stb = 8'd1 << (int'(a) - 8);
                    end else begin
                        m_data = 8'h00;
                        m_err  = 1'b1;
                    end
                    m_oe = oel;
                end
            end
        end
        err_clr = 1'b0;
        chk("rdy_latency", 64'(rise_k), 64'(LAT_A));
        @(negedge clk);
        cs_n    = 1'b1;
        oe_n    = 1'b1;
        fall_cd = 3;
        for (int g = 0; g < gap; g++) tick();
    endtask

    initial begin
        int lat;
        logic [63:0] rst_v;
        rst_n = 1'b0; cs_n = 1'b1; cs_n_b = 1'b1; oe_n = 1'b1; wr_n = 1'b1;
        addr = '0; data_i = '0; rd_regs = '0; err_clr = 1'b0;
        rst_v = WR_RST;
        for (int i = 0; i < 8; i++) m_regs[i] = rst_v[i*8 +: 8];
        m_rdy = 0; m_oe = 0; m_err = 0; m_data = 0; m_wr_stb = 0; m_rd_stb = 0;
        rises = 0; wr_pulses = 0; rd_pulses = 0; last_wr = 0; last_rd = 0; oe_seen = 0;

        repeat (3) @(negedge clk);
        chk("reset_reg0", {56'd0, wr_regs[7:0]}, 64'h5A);
        chk("reset_rdy", {63'd0, rdy}, 64'd0);
        chk("reset_oe", {63'd0, data_oe}, 64'd0);
        chk("reset_err", {63'd0, err}, 64'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        repeat (2) tick();

        // Write addr 3
        wr_pulses = 0;
        do_txn(6'd3, 1'b1, 8'hA5, 1'b0, 2, 2, -1);
        chk("wr3_value", {56'd0, wr_regs[31:24]}, 64'hA5);
        chk("wr3_stb_pulses", 64'(wr_pulses), 64'd1);
        chk("wr3_stb_value", {56'd0, last_wr}, 64'h08);

        // Read RO reg 2 at addr 10
        rd_regs = 64'h1111_1111_11C3_1111;
        rd_pulses = 0; oe_seen = 0;
        do_txn(6'd10, 1'b0, 8'h00, 1'b1, 2, 2, -1);
        chk("rd10_data", {56'd0, data_o}, 64'hC3);
        chk("rd10_stb_pulses", 64'(rd_pulses), 64'd1);
        chk("rd10_stb_value", {56'd0, last_rd}, 64'h04);
        chk("rd10_oe_seen", {63'd0, oe_seen}, 64'd1);

        // Unmapped read, then clear the sticky error
        do_txn(6'd20, 1'b0, 8'h00, 1'b1, 1, 3, -1);
        chk("rd20_data", {56'd0, data_o}, 64'h00);
        chk("rd20_err", {63'd0, err}, 64'd1);
        @(negedge clk);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_cleared", {63'd0, err}, 64'd0);

        // Back-to-back writes with a single-cycle cs_n gap
        rises = 0;
        do_txn(6'd0, 1'b1, 8'h11, 1'b0, 0, 1, -1);
        do_txn(6'd1, 1'b1, 8'h22, 1'b0, 0, 3, -1);
        chk("b2b_rises", 64'(rises), 64'd2);
        chk("b2b_regs", {48'd0, wr_regs[15:0]}, 64'h2211);

        // Abort during WAIT on the 4-wait-state instance
        @(negedge clk);
        addr = 6'd2; wr_n = 1'b0; data_i = 8'hEE; cs_n_b = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        cs_n_b = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("abort_rdy", {63'd0, rdy_b}, 64'd0);
            chk("abort_stb", {48'd0, wr_stb_b, rd_stb_b}, 64'd0);
        end
        chk("abort_regs", wr_regs_b, WR_RST);
        chk("abort_err", {63'd0, err_b}, 64'd0);

        // The same instance still completes a full access afterwards
        @(negedge clk);
        cs_n_b = 1'b0;
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (rdy_b) begin
                lat = k;
                break;
            end
        end
        chk("b_latency", 64'(lat), 64'(LAT_B));
        chk("b_wr_value", {56'd0, wr_regs_b[23:16]}, 64'hEE);
        @(negedge clk);
        cs_n_b = 1'b1;
        wr_n   = 1'b1;
        repeat (4) tick();

        // Random traffic against the model
        for (int t = 0; t < 40; t++) begin
            logic [5:0] ra;
            ra = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
            rd_regs = {$urandom, $urandom};
            do_txn(ra, 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), int'($urandom_range(0, 15)));
        end

        repeat (5) tick();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
